// File: rtl/mulcc_pkg.sv
// Shared helpers for the column-compression multiplier: count width,
// per-column ones bound, and the stage valid vector type.
package mulcc_pkg;

  localparam int MULCC_STAGES = 3;

  typedef logic [MULCC_STAGES-1:0] mulcc_vld_t;

  function automatic int mulcc_cw(input int width);
    return $clog2(2 * width);
  endfunction

  // Partial-product ones that can land in column k of a width x width array.
  function automatic int mulcc_colmax(input int k, input int width);
    if (k < width)
      return k + 1;
    else if (k <= 2 * width - 2)
      return 2 * width - 1 - k;
    else
      return 0;
  endfunction

endpackage

// File: rtl/mulcc_colsum.sv
// Parametrised popcount: counts the ones among N column bits into a CW-bit sum.
module mulcc_colsum #(
  parameter int N  = 6,
  parameter int CW = 4
) (
  input  logic [N-1:0]  i_bits,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/mul_colcomp_pipe.sv
// Three-stage pipelined column-compression multiplier on valid/ready streams.
// Optional two's-complement mode (Baugh-Wooley) is enabled by MULCC_SIGNED_EN.
module mul_colcomp_pipe
  import mulcc_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef MULCC_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_p
);

  localparam int CW = mulcc_cw(WIDTH);

  // Handshake: a stage may load when it is empty or the stage after it is
  // loading this cycle; data is only ever written on a transfer.
  mulcc_vld_t       r_vld;
  logic [2:0]       w_rdy;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt [PW];
  logic [PW-1:0]    r_p;

  logic [WIDTH-1:0] w_col     [PW];
  logic [CW-1:0]    w_cnt     [PW];
  logic [CW-1:0]    w_cnt_adj [PW];
  logic [CW:0]      w_t       [PW];
  logic [CW-1:0]    w_cy;
  logic [PW-1:0]    w_sum;

`ifdef MULCC_SIGNED_EN
  logic r_s0_signed;
  logic r_s1_signed;
`endif

  assign w_rdy[2]  = !r_vld[2] || out_ready;
  assign w_rdy[1]  = !r_vld[1] || w_rdy[2];
  assign w_rdy[0]  = !r_vld[0] || w_rdy[1];
  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[2];
  assign out_p     = r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_rdy[0]) r_vld[0] <= in_valid;
      if (w_rdy[1]) r_vld[1] <= r_vld[0];
      if (w_rdy[2]) r_vld[2] <= r_vld[1];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_rdy[0]) begin
      r_a <= in_a;
      r_b <= in_b;
`ifdef MULCC_SIGNED_EN
      r_s0_signed <= in_signed;
`endif
    end
  end

  // Column k collects pp[i][k-i]; bit position i within the column is the row.
  always_comb begin
    for (int k = 0; k < PW; k++) begin
      w_col[k] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
`ifdef MULCC_SIGNED_EN
        w_col[i+j][i] = (r_a[j] & r_b[i]) ^
                        (r_s0_signed & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
`else
        w_col[i+j][i] = r_a[j] & r_b[i];
`endif
      end
    end
  end

  for (genvar k = 0; k < PW; k++) begin : g_col
    mulcc_colsum #(
      .N  (WIDTH),
      .CW (CW)
    ) u_colsum (
      .i_bits  (w_col[k]),
      .o_count (w_cnt[k])
    );
  end

  // Baugh-Wooley constant ones enter columns WIDTH and PW-1 as count increments.
  always_comb begin
    for (int k = 0; k < PW; k++) begin
      w_cnt_adj[k] = w_cnt[k];
`ifdef MULCC_SIGNED_EN
      if (r_s0_signed && (k == WIDTH || k == PW - 1))
        w_cnt_adj[k] = w_cnt[k] + CW'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (r_vld[0] && w_rdy[1]) begin
      for (int k = 0; k < PW; k++) begin
        r_cnt[k] <= w_cnt_adj[k];
      end
`ifdef MULCC_SIGNED_EN
      r_s1_signed <= r_s0_signed;
`endif
    end
  end

  always_comb begin
    w_cy  = '0;
    w_sum = '0;
    w_t   = '{default: '0};
    for (int k = 0; k < PW; k++) begin
      w_t[k]   = {1'b0, r_cnt[k]} + {1'b0, w_cy};
      w_sum[k] = w_t[k][0];
      w_cy     = w_t[k][CW:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (r_vld[1] && w_rdy[2]) begin
      r_p <= w_sum;
`ifdef MULCC_SIGNED_EN
      // Signed results wrap mod 2^PW, so a carry out is legal only there.
      assert (r_s1_signed || w_cy == '0);
      for (int k = 0; k < PW; k++) begin
        assert (int'(r_cnt[k]) <= mulcc_colmax(k, WIDTH) +
                ((k == WIDTH || k == PW - 1) ? 1 : 0));
      end
`else
      assert (w_cy == '0);
      for (int k = 0; k < PW; k++) begin
        assert (int'(r_cnt[k]) <= mulcc_colmax(k, WIDTH));
      end
`endif
    end
  end

endmodule
